branch_resolve_unit: RTL and testbench

- Parametrised successor to the combinational branch-decision logic of the 3-stage MIPS core.
- Resolves all conditional branch types in EX, not only BEQ-on-Zero.
- Predicts direction for ID using a 2-bit saturating branch history table (BHT). Issues registered redirect/flush requests.
- Detects self-loop branches: a trap fires after LOOP_LIMIT consecutive hits, instead of flagging every self-branch. Keeps saturating performance counters.

---
 rtl/mips_pkg.sv | 15 +
 rtl/bht_2bit.sv | 40 ++++
 rtl/branch_resolve_unit.sv | 120 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS core branch path: branch type encodings,
// BHT counter reset value and the instruction byte step.
package mips_pkg;

   localparam logic [2:0] BR_BEQ  = 3'd0;
   localparam logic [2:0] BR_BNE  = 3'd1;
   localparam logic [2:0] BR_BLEZ = 3'd2;
   localparam logic [2:0] BR_BGTZ = 3'd3;
   localparam logic [2:0] BR_BLTZ = 3'd4;
   localparam logic [2:0] BR_BGEZ = 3'd5;

   localparam logic [1:0] BHT_RESET = 2'b01;
   localparam int unsigned INSN_BYTES = 4;

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters with a combinational
// read port and a synchronous saturating update port.
module bht_2bit
   import mips_pkg::*;
#(
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [1:0]       rd_ctr,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken
);

   localparam int ENTRIES = 2 ** IDX_W;

   logic [1:0] ctr [ENTRIES];

   function automatic logic [1:0] sat_step(input logic [1:0] v, input logic up);
      if (up)
         return (v == 2'b11) ? v : v + 2'b01;
      else
         return (v == 2'b00) ? v : v - 2'b01;
   endfunction

   // Read returns the stored value; a same-cycle update is not bypassed.
   assign rd_ctr = ctr[rd_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++)
            ctr[i] <= BHT_RESET;
      end else if (upd_en) begin
         ctr[upd_idx] <= sat_step(ctr[upd_idx], upd_taken);
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches in EX, predicts direction for ID from a 2-bit
// BHT, issues registered redirects and traps on long self-loop branches.
module branch_resolve_unit
   import mips_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int IDX_W      = 6,
   parameter int LOOP_LIMIT = 16,
   parameter int CNT_W      = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] id_pc,
   output logic            id_pred_taken,
   input  logic            ex_valid,
   input  logic [2:0]      ex_type,
   input  logic [XLEN-1:0] ex_rs,
   input  logic [XLEN-1:0] ex_rt,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_target,
   input  logic            ex_pred_taken,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            mispredict,
   output logic            branch_error,
   output logic [XLEN-1:0] error_pc,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam int LOOP_W = $clog2(LOOP_LIMIT + 1);
   localparam logic signed [XLEN-1:0] ZERO_S = '0;

   logic signed [XLEN-1:0] rs_s;
   logic                   type_ok;
   logic                   taken;
   logic                   resolve;
   logic                   mispred_d;
   logic                   self_hit;
   logic [XLEN-1:0]        actual_pc;
   logic [LOOP_W-1:0]      loop_cnt;
   logic [1:0]             rd_ctr;
   logic                   unused_ok;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign rs_s = ex_rs;

   always_comb begin
      type_ok = 1'b1;
      taken   = 1'b0;
      case (ex_type)
         BR_BEQ:  taken = (ex_rs == ex_rt);
         BR_BNE:  taken = (ex_rs != ex_rt);
         BR_BLEZ: taken = (rs_s <= ZERO_S);
         BR_BGTZ: taken = (rs_s >  ZERO_S);
         BR_BLTZ: taken = (rs_s <  ZERO_S);
         BR_BGEZ: taken = (rs_s >= ZERO_S);
         default: type_ok = 1'b0;
      endcase
   end

   assign resolve   = ex_valid && type_ok && !branch_error;
   assign actual_pc = taken ? ex_target : ex_pc + XLEN'(INSN_BYTES);
   assign mispred_d = (taken != ex_pred_taken);
   assign self_hit  = taken && (ex_target == ex_pc);

   bht_2bit #(
      .IDX_W(IDX_W)
   ) u_bht (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_idx    (id_pc[IDX_W+1:2]),
      .rd_ctr    (rd_ctr),
      .upd_en    (resolve),
      .upd_idx   (ex_pc[IDX_W+1:2]),
      .upd_taken (taken)
   );

   assign id_pred_taken = rd_ctr[1] && !branch_error;
   assign unused_ok     = ^{id_pc[XLEN-1:IDX_W+2], id_pc[1:0], rd_ctr[0]};

   // EX resolve -> registered redirect, counters and loop trap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         mispredict     <= 1'b0;
         branch_error   <= 1'b0;
         error_pc       <= '0;
         branch_cnt     <= '0;
         mispred_cnt    <= '0;
         loop_cnt       <= '0;
      end else begin
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         mispredict     <= 1'b0;
         if (resolve) begin
            redirect_valid <= mispred_d;
            mispredict     <= mispred_d;
            redirect_pc    <= mispred_d ? actual_pc : '0;
            branch_cnt     <= sat_inc(branch_cnt);
            if (mispred_d)
               mispred_cnt <= sat_inc(mispred_cnt);
            if (self_hit) begin
               loop_cnt <= loop_cnt + 1'b1;
               if (loop_cnt == LOOP_W'(LOOP_LIMIT - 1)) begin
                  branch_error <= 1'b1;
                  error_pc     <= ex_pc;
               end
            end else begin
               loop_cnt <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: one instance with LOOP_LIMIT=4 and
// one with CNT_W=2 sharing the same stimulus.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] id_pc = '0;
   logic        ex_valid = 1'b0;
   logic [2:0]  ex_type = '0;
   logic [31:0] ex_rs = '0, ex_rt = '0, ex_pc = '0, ex_target = '0;
   logic        ex_pred_taken = 1'b0;

   logic        id_pred_taken, redirect_valid, mispredict, branch_error;
   logic [31:0] redirect_pc, error_pc;
   logic [15:0] branch_cnt, mispred_cnt;

   logic        c_pred, c_rv, c_misp, c_err;
   logic [31:0] c_rpc, c_epc;
   logic [1:0]  c_bcnt, c_mcnt;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   branch_resolve_unit #(.XLEN(32), .IDX_W(6), .LOOP_LIMIT(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .id_pc(id_pc), .id_pred_taken(id_pred_taken),
      .ex_valid(ex_valid), .ex_type(ex_type), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mispredict(mispredict), .branch_error(branch_error), .error_pc(error_pc),
      .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   branch_resolve_unit #(.XLEN(32), .IDX_W(6), .LOOP_LIMIT(16), .CNT_W(2)) dut_c (
      .clk(clk), .rst_n(rst_n), .id_pc(id_pc), .id_pred_taken(c_pred),
      .ex_valid(ex_valid), .ex_type(ex_type), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
      .redirect_valid(c_rv), .redirect_pc(c_rpc),
      .mispredict(c_misp), .branch_error(c_err), .error_pc(c_epc),
      .branch_cnt(c_bcnt), .mispred_cnt(c_mcnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic br(input logic [2:0] t, input logic [31:0] rs, input logic [31:0] rt,
                     input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
      ex_type = t; ex_rs = rs; ex_rt = rt; ex_pc = pc; ex_target = tgt;
      ex_pred_taken = pred; ex_valid = 1'b1;
      @(posedge clk); #1;
      ex_valid = 1'b0;
   endtask

   task automatic redir(input string tag, input logic rv, input logic [31:0] rpc);
      chk({tag, "_rv"}, 32'(redirect_valid), 32'(rv));
      chk({tag, "_misp"}, 32'(mispredict), 32'(rv));
      chk({tag, "_rpc"}, redirect_pc, rpc);
   endtask

   initial begin
      id_pc = 32'h100;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rv", 32'(redirect_valid), 0);
      chk("rst_rpc", redirect_pc, 0);
      chk("rst_err", 32'(branch_error), 0);
      chk("rst_bcnt", 32'(branch_cnt), 0);
      chk("rst_mcnt", 32'(mispred_cnt), 0);
      chk("rst_pred", 32'(id_pred_taken), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // BEQ taken, predicted not-taken
      br(3'd0, 5, 5, 32'h100, 32'h200, 1'b0);
      redir("beq1", 1'b1, 32'h200);
      chk("beq1_mcnt", 32'(mispred_cnt), 1);
      chk("beq1_bcnt", 32'(branch_cnt), 1);
      br(3'd0, 5, 5, 32'h100, 32'h200, 1'b1);
      redir("beq2", 1'b0, 32'h0);
      chk("beq2_pred", 32'(id_pred_taken), 1);
      chk("beq2_bcnt", 32'(branch_cnt), 2);

      // BNE not taken, correct then wrong prediction
      br(3'd1, 7, 7, 32'h40, 32'h900, 1'b0);
      redir("bne1", 1'b0, 32'h0);
      chk("bne1_bcnt", 32'(branch_cnt), 3);
      br(3'd1, 7, 7, 32'h40, 32'h900, 1'b1);
      redir("bne2", 1'b1, 32'h44);
      chk("bne2_mcnt", 32'(mispred_cnt), 2);
      id_pc = 32'h40; #1;
      chk("bne_pred", 32'(id_pred_taken), 0);

      // Signed forms, rs = -1
      br(3'd4, 32'hFFFF_FFFF, 0, 32'h80, 32'h300, 1'b0);
      redir("bltz_m1", 1'b1, 32'h300);
      br(3'd5, 32'hFFFF_FFFF, 0, 32'h80, 32'h300, 1'b0);
      redir("bgez_m1", 1'b0, 32'h0);
      br(3'd2, 32'hFFFF_FFFF, 0, 32'h80, 32'h304, 1'b0);
      redir("blez_m1", 1'b1, 32'h304);
      br(3'd3, 32'hFFFF_FFFF, 0, 32'h80, 32'h304, 1'b1);
      redir("bgtz_m1", 1'b1, 32'h84);
      chk("sat_mcnt", 32'(c_mcnt), 3);
      chk("sat_bcnt", 32'(c_bcnt), 3);
      chk("m1_mcnt", 32'(mispred_cnt), 5);

      // Signed forms, rs = 0
      br(3'd2, 0, 0, 32'h80, 32'h308, 1'b1);
      redir("blez_0", 1'b0, 32'h0);
      br(3'd5, 0, 0, 32'h80, 32'h30C, 1'b0);
      redir("bgez_0", 1'b1, 32'h30C);
      br(3'd3, 0, 0, 32'h80, 32'h30C, 1'b1);
      redir("bgtz_0", 1'b1, 32'h84);
      br(3'd6, 5, 5, 32'h80, 32'h30C, 1'b0);
      redir("rsvd", 1'b0, 32'h0);
      chk("rsvd_bcnt", 32'(branch_cnt), 11);
      chk("rsvd_mcnt", 32'(mispred_cnt), 7);

      // Same-cycle lookup and update of index 8
      id_pc = 32'h20;
      ex_type = 3'd0; ex_rs = 1; ex_rt = 1; ex_pc = 32'h20; ex_target = 32'h500;
      ex_pred_taken = 1'b1; ex_valid = 1'b1;
      #1;
      chk("same_old", 32'(id_pred_taken), 0);
      @(posedge clk); #1;
      ex_valid = 1'b0;
      chk("same_new", 32'(id_pred_taken), 1);

      // 3 self-loops, a normal branch, 3 self-loops: no trap
      repeat (3) br(3'd0, 1, 1, 32'h600, 32'h600, 1'b1);
      br(3'd0, 1, 1, 32'h20, 32'h500, 1'b1);
      repeat (3) br(3'd0, 1, 1, 32'h600, 32'h600, 1'b1);
      chk("noloop_err", 32'(branch_error), 0);
      chk("noloop_bcnt", 32'(branch_cnt), 19);

      // Clear the loop count, then 4 back-to-back self-loops trap
      br(3'd0, 1, 1, 32'h20, 32'h500, 1'b1);
      repeat (3) br(3'd0, 1, 1, 32'h600, 32'h600, 1'b0);
      chk("loop3_err", 32'(branch_error), 0);
      br(3'd0, 1, 1, 32'h600, 32'h600, 1'b0);
      chk("loop4_err", 32'(branch_error), 1);
      chk("loop4_epc", error_pc, 32'h600);
      redir("loop4", 1'b1, 32'h600);
      chk("loop4_bcnt", 32'(branch_cnt), 24);
      chk("loop4_mcnt", 32'(mispred_cnt), 11);

      // Frozen after trap
      id_pc = 32'h100;
      br(3'd0, 5, 5, 32'h100, 32'h200, 1'b0);
      redir("frozen", 1'b0, 32'h0);
      chk("frozen_bcnt", 32'(branch_cnt), 24);
      chk("frozen_mcnt", 32'(mispred_cnt), 11);
      chk("frozen_pred", 32'(id_pred_taken), 0);
      chk("frozen_err", 32'(branch_error), 1);

      // Reset clears the trap; reset mid-redirect drops outputs at once
      rst_n = 1'b0; #2; rst_n = 1'b1;
      chk("rerst_err", 32'(branch_error), 0);
      @(posedge clk); #1;
      br(3'd0, 5, 5, 32'h100, 32'h200, 1'b0);
      redir("pre_rst", 1'b1, 32'h200);
      rst_n = 1'b0; #1;
      redir("mid_rst", 1'b0, 32'h0);
      chk("mid_rst_bcnt", 32'(branch_cnt), 0);
      chk("mid_rst_mcnt", 32'(mispred_cnt), 0);
      chk("mid_rst_epc", error_pc, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_rv", 32'(redirect_valid), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
